piece_drop_ctrl: RTL



---
 rtl/piece_drop_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl
// ---------------
// Gravity and drop controller for the Tetris core. Turns the gravity tick,
// the held soft-drop key and the hard-drop pulse into move-down requests to
// the board logic over a req/ack handshake. It tracks how many consecutive
// down attempts were blocked and asks for a lock once the lock delay runs
// out. It also reports how many rows the last hard drop covered, for scoring.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   enable_i     game running; only looked at in IDLE and WAIT
//   tick_i       one-cycle gravity pulse from the clock divisor
//   soft_drop_i  level, down key held
//   hard_drop_i  one-cycle hard-drop pulse
//   down_req_o   move-down request, held until down_ack_i
//   down_ack_i   board response, only meaningful while down_req_o=1
//   down_ok_i    valid with down_ack_i: 1 = piece moved, 0 = blocked
//   lock_req_o   lock-piece request, held until lock_ack_i
//   lock_ack_i   lock done, next piece spawned
//   grounded_o   last down attempt was blocked
//   drop_rows_o  rows moved by the most recent hard drop, saturating at 31
//
// SOFT_PERIOD must be at least 2 and LOCK_TICKS at least 1.

module piece_drop_ctrl #(
   parameter int unsigned SOFT_PERIOD = 15000000,
   parameter int unsigned LOCK_TICKS  = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       tick_i,
   input  logic       soft_drop_i,
   input  logic       hard_drop_i,
   output logic       down_req_o,
   input  logic       down_ack_i,
   input  logic       down_ok_i,
   output logic       lock_req_o,
   input  logic       lock_ack_i,
   output logic       grounded_o,
   output logic [4:0] drop_rows_o
);

   localparam int unsigned GW = $clog2(LOCK_TICKS + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      REQ,
      HARD,
      HGAP,
      LOCK
   } state_t;

   state_t        state_q, state_d;
   logic          downReq_q, downReq_d;
   logic          lockReq_q, lockReq_d;
   logic          grounded_q, grounded_d;
   logic [4:0]    dropRows_q, dropRows_d;
   logic [GW-1:0] groundCnt_q, groundCnt_d;
   logic [31:0]   softCnt_q, softCnt_d;
   logic          softTick;
   logic          lockDue;

   // Soft-drop repeat counter. It runs in every state while the key is held
   // and restarts from zero as soon as the key is released, so a fresh press
   // always waits the full SOFT_PERIOD-1 cycles before its first trigger.
   always_comb begin
      softTick  = 1'b0;
      softCnt_d = softCnt_q + 32'd1;
      if (!soft_drop_i) begin
         softCnt_d = '0;
      end else if (softCnt_q == SOFT_PERIOD - 1) begin
         softTick  = 1'b1;
         softCnt_d = '0;
      end
   end

   // This blocked attempt would bring the run of blocked attempts up to the
   // lock delay, so the piece locks instead of going back to WAIT.
   assign lockDue = (32'(groundCnt_q) + 32'd1) >= LOCK_TICKS;

   // Next-state logic. Triggers are only consumed in WAIT; anything that
   // arrives in another state is simply dropped. The request outputs are
   // decoded from the next state so that they come straight out of flops.
   always_comb begin
      state_d     = state_q;
      grounded_d  = grounded_q;
      groundCnt_d = groundCnt_q;
      dropRows_d  = dropRows_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i) state_d = WAIT;
         end
         WAIT: begin
            if (!enable_i) begin
               state_d = IDLE;
            end else if (hard_drop_i) begin
               state_d    = HARD;
               dropRows_d = '0;
            end else if (tick_i || softTick) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (down_ack_i) begin
               if (down_ok_i) begin
                  state_d     = WAIT;
                  grounded_d  = 1'b0;
                  groundCnt_d = '0;
               end else begin
                  grounded_d = 1'b1;
                  if (lockDue) begin
                     state_d = LOCK;
                  end else begin
                     state_d     = WAIT;
                     groundCnt_d = groundCnt_q + GW'(1);
                  end
               end
            end
         end
         HARD: begin
            if (down_ack_i) begin
               if (down_ok_i) begin
                  state_d = HGAP;
                  if (dropRows_q != 5'd31) dropRows_d = dropRows_q + 5'd1;
               end else begin
                  state_d    = LOCK;
                  grounded_d = 1'b1;
               end
            end
         end
         HGAP: begin
            state_d = HARD;
         end
         LOCK: begin
            if (lock_ack_i) begin
               state_d     = WAIT;
               grounded_d  = 1'b0;
               groundCnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      downReq_d = (state_d == REQ) || (state_d == HARD);
      lockReq_d = (state_d == LOCK);
   end

   // State and output registers; reset clears everything on the next edge,
   // even in the middle of a handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         downReq_q   <= 1'b0;
         lockReq_q   <= 1'b0;
         grounded_q  <= 1'b0;
         dropRows_q  <= '0;
         groundCnt_q <= '0;
         softCnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         downReq_q   <= downReq_d;
         lockReq_q   <= lockReq_d;
         grounded_q  <= grounded_d;
         dropRows_q  <= dropRows_d;
         groundCnt_q <= groundCnt_d;
         softCnt_q   <= softCnt_d;
      end
   end

   assign down_req_o  = downReq_q;
   assign lock_req_o  = lockReq_q;
   assign grounded_o  = grounded_q;
   assign drop_rows_o = dropRows_q;

endmodule
